// File: rtl/pipe_event_tracer.sv
// pipe_event_tracer: statistics counters and buffered writeback trace stream for the 5-stage CPU.
// Each register writeback to a non-zero destination becomes a 64-bit record
// {cycle[26:0], rd[4:0], data[31:0]} queued in a DEPTH-entry FIFO behind a valid/ready port.
// Optional feature: define TRACE_STALL_EN to also queue marker records for stall/flush cycles.
module pipe_event_tracer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             wb_en_i,
    input  logic [4:0]       wb_addr_i,
    input  logic [31:0]      wb_data_i,
    output logic             trace_valid_o,
    input  logic             trace_ready_i,
    output logic [63:0]      trace_data_o,
    output logic             drop_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] retire_cnt_o
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FULL_OCC = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Statistics counters
    logic [CNT_W-1:0] cycleCnt_q, cycleCnt_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0] flushCnt_q, flushCnt_d;
    logic [CNT_W-1:0] retireCnt_q, retireCnt_d;

    // FIFO storage, pointers, occupancy and registered head
    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             valid_q, valid_d;
    logic [63:0]      data_q, data_d;
    logic             drop_q, drop_d;

    // Event decode and record assembly
    logic [26:0]      stamp;
    logic             wbEvent;
    logic             pushReq;
    logic [63:0]      pushRec;
    logic             full;
    logic             popFire;
    logic             doPush;
    logic             memWe;

    // The timestamp is the low 27 bits of the cycle counter, zero-extended if the counter is narrower
    generate
        if (CNT_W >= 27) begin : gStampSlice
            assign stamp = cycleCnt_q[26:0];
        end else begin : gStampExt
            assign stamp = {{(27 - CNT_W){1'b0}}, cycleCnt_q};
        end
    endgenerate

    // Saturating increment: counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

`ifdef TRACE_STALL_EN
    logic markEvent;

    // A stall/flush cycle without a writeback produces a marker; a writeback in the same cycle wins
    always_comb begin
        wbEvent   = start_i & wb_en_i & (wb_addr_i != 5'd0);
        markEvent = start_i & (stall_i | flush_i) & ~wbEvent;
        pushReq   = wbEvent | markEvent;
        if (wbEvent) begin
            pushRec = {stamp, wb_addr_i, wb_data_i};
        end else begin
            pushRec = {stamp, 5'd0, 30'd0, flush_i, stall_i};
        end
    end
`else
    // Only writebacks to a non-zero register while the CPU runs are traced
    always_comb begin
        wbEvent = start_i & wb_en_i & (wb_addr_i != 5'd0);
        pushReq = wbEvent;
        pushRec = {stamp, wb_addr_i, wb_data_i};
    end
`endif

    // Next-state logic for counters and FIFO; clear overrides every event in the same cycle
    always_comb begin
        cycleCnt_d  = cycleCnt_q;
        stallCnt_d  = stallCnt_q;
        flushCnt_d  = flushCnt_q;
        retireCnt_d = retireCnt_q;

        if (start_i) begin
            cycleCnt_d = satInc(cycleCnt_q);
            if (stall_i) begin
                stallCnt_d = satInc(stallCnt_q);
            end
            if (flush_i) begin
                flushCnt_d = satInc(flushCnt_q);
            end
            if (wbEvent) begin
                retireCnt_d = satInc(retireCnt_q);
            end
        end

        full    = (count_q == FULL_OCC);
        popFire = valid_q & trace_ready_i;
        // When full, a simultaneous pop frees the slot the push lands in
        doPush  = pushReq & (~full | popFire);
        drop_d  = drop_q | (pushReq & full & ~popFire);

        rdPtr_d = popFire ? rdPtr_q + PTR_ONE : rdPtr_q;
        wrPtr_d = doPush  ? wrPtr_q + PTR_ONE : wrPtr_q;

        case ({doPush, popFire})
            2'b10:   count_d = count_q + OCC_ONE;
            2'b01:   count_d = count_q - OCC_ONE;
            default: count_d = count_q;
        endcase

        valid_d = (count_d != '0);

        // The head register preloads the next entry; a push into an empty slot bypasses storage
        if (count_d == '0) begin
            data_d = data_q;
        end else if (doPush && (rdPtr_d == wrPtr_q)) begin
            data_d = pushRec;
        end else begin
            data_d = mem_q[rdPtr_d];
        end

        memWe = doPush;

        if (clear_i) begin
            cycleCnt_d  = '0;
            stallCnt_d  = '0;
            flushCnt_d  = '0;
            retireCnt_d = '0;
            drop_d      = 1'b0;
            rdPtr_d     = '0;
            wrPtr_d     = '0;
            count_d     = '0;
            valid_d     = 1'b0;
            data_d      = '0;
            memWe       = 1'b0;
        end
    end

    // State registers with asynchronous reset to the empty, zeroed state
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cycleCnt_q  <= '0;
            stallCnt_q  <= '0;
            flushCnt_q  <= '0;
            retireCnt_q <= '0;
            drop_q      <= 1'b0;
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
        end else begin
            cycleCnt_q  <= cycleCnt_d;
            stallCnt_q  <= stallCnt_d;
            flushCnt_q  <= flushCnt_d;
            retireCnt_q <= retireCnt_d;
            drop_q      <= drop_d;
            rdPtr_q     <= rdPtr_d;
            wrPtr_q     <= wrPtr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
        end
    end

    // FIFO storage needs no reset: occupancy and the head register gate what is visible
    always_ff @(posedge clk_i) begin
        if (memWe) begin
            mem_q[wrPtr_q] <= pushRec;
        end
    end

    assign trace_valid_o = valid_q;
    assign trace_data_o  = data_q;
    assign drop_o        = drop_q;
    assign cycle_cnt_o   = cycleCnt_q;
    assign stall_cnt_o   = stallCnt_q;
    assign flush_cnt_o   = flushCnt_q;
    assign retire_cnt_o  = retireCnt_q;

endmodule

// File: tb/tb_pipe_event_tracer.sv
// tb_pipe_event_tracer: directed stimulus with a scoreboard queue for pipe_event_tracer.
// Marker-record expectations are enabled when TRACE_STALL_EN is defined.
`timescale 1ns/1ps
module tb_pipe_event_tracer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             clear;
    logic             stall;
    logic             flush;
    logic             wbEn;
    logic [4:0]       wbAddr;
    logic [31:0]      wbData;
    logic             traceValid;
    logic             traceReady;
    logic [63:0]      traceData;
    logic             drop;
    logic [CNT_W-1:0] cycleCnt;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;
    logic [CNT_W-1:0] retireCnt;

    int               checkCnt = 0;
    int               passCnt  = 0;
    logic [63:0]      expQ[$];
    logic [31:0]      expCyc = 32'd0;
    int               drainCycles;

    pipe_event_tracer #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .clear_i      (clear),
        .stall_i      (stall),
        .flush_i      (flush),
        .wb_en_i      (wbEn),
        .wb_addr_i    (wbAddr),
        .wb_data_i    (wbData),
        .trace_valid_o(traceValid),
        .trace_ready_i(traceReady),
        .trace_data_o (traceData),
        .drop_o       (drop),
        .cycle_cnt_o  (cycleCnt),
        .stall_cnt_o  (stallCnt),
        .flush_cnt_o  (flushCnt),
        .retire_cnt_o (retireCnt)
    );

    always #5 clk = ~clk;

    // Compare one observed value against the bench's expectation
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCnt++;
        if (actual === expected) begin
            passCnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    // Advance one clock; track the cycle count the DUT should be stamping
    task automatic tick();
        @(posedge clk);
        if (rst_n && !clear && start) begin
            expCyc++;
        end
        #1;
    endtask

    // Drive one cycle of CPU activity; queue the record it should produce when it is kept
    task automatic applyStimulus(input logic st, input logic stl, input logic fl, input logic we,
                                 input logic [4:0] addr, input logic [31:0] data, input logic keep);
        logic ev;
        start  = st;
        stall  = stl;
        flush  = fl;
        wbEn   = we;
        wbAddr = addr;
        wbData = data;
        ev = st && we && (addr != 5'd0);
        if (keep && ev) begin
            expQ.push_back({expCyc[26:0], addr, data});
        end
`ifdef TRACE_STALL_EN
        else if (keep && st && (stl || fl)) begin
            expQ.push_back({expCyc[26:0], 5'd0, 30'd0, fl, stl});
        end
`endif
        tick();
    endtask

    // Pulse clear, optionally with every kind of event in the same cycle
    task automatic doClear(input logic withEvent);
        clear  = 1'b1;
        start  = 1'b1;
        stall  = withEvent;
        flush  = withEvent;
        wbEn   = withEvent;
        wbAddr = 5'd3;
        wbData = 32'hCAFE_0001;
        tick();
        clear  = 1'b0;
        stall  = 1'b0;
        flush  = 1'b0;
        wbEn   = 1'b0;
        expCyc = 32'd0;
    endtask

    // Let the consumer accept until the scoreboard and the DUT are both empty
    task automatic waitDrain(input string name, output int cycles);
        int n;
        n          = 0;
        wbEn       = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        traceReady = 1'b1;
        while ((expQ.size() != 0 || traceValid) && n < 40) begin
            tick();
            n++;
        end
        cycles = n;
        checkOutput({name, " pending records"}, 64'(expQ.size()), 64'd0);
        checkOutput({name, " valid after drain"}, {63'd0, traceValid}, 64'd0);
    endtask

    // Monitor: every accepted record must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && !clear && traceValid && traceReady) begin
            if (expQ.size() == 0) begin
                checkCnt++;
                $display("[TB] FAIL unexpected record: got 0x%h, expected none", traceData);
            end else begin
                checkOutput("record", traceData, expQ.pop_front());
            end
        end
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got %0d/%0d", passCnt, checkCnt);
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence
    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        clear      = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        wbEn       = 1'b0;
        wbAddr     = 5'd0;
        wbData     = 32'd0;
        traceReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] reset state");
        checkOutput("reset valid", {63'd0, traceValid}, 64'd0);
        checkOutput("reset data", traceData, 64'd0);
        checkOutput("reset drop", {63'd0, drop}, 64'd0);
        checkOutput("reset cycle", 64'(cycleCnt), 64'd0);

        $display("[TB] ten idle running cycles");
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        checkOutput("idle cycle", 64'(cycleCnt), 64'd10);
        checkOutput("idle stall", 64'(stallCnt), 64'd0);
        checkOutput("idle flush", 64'(flushCnt), 64'd0);
        checkOutput("idle retire", 64'(retireCnt), 64'd0);
        checkOutput("idle valid", {63'd0, traceValid}, 64'd0);

        $display("[TB] clear with coincident events");
        doClear(1'b1);
        checkOutput("clear cycle", 64'(cycleCnt), 64'd0);
        checkOutput("clear stall", 64'(stallCnt), 64'd0);
        checkOutput("clear retire", 64'(retireCnt), 64'd0);
        checkOutput("clear valid", {63'd0, traceValid}, 64'd0);

        $display("[TB] single event in counted cycle 3");
        traceReady = 1'b1;
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_000F, 1'b1);
        checkOutput("single valid", {63'd0, traceValid}, 64'd1);
        checkOutput("single data", traceData, 64'h0000_0065_0000_000F);
        checkOutput("single retire", 64'(retireCnt), 64'd1);
        waitDrain("single", drainCycles);

        $display("[TB] overflow with consumer stalled");
        doClear(1'b0);
        traceReady = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'(i), 32'h100 + 32'(i), i <= DEPTH);
        end
        wbEn = 1'b0;
        checkOutput("overflow retire", 64'(retireCnt), 64'd10);
        checkOutput("overflow drop", {63'd0, drop}, 64'd1);
        checkOutput("overflow valid", {63'd0, traceValid}, 64'd1);
        checkOutput("overflow head", traceData, 64'h0000_0001_0000_0101);
        waitDrain("overflow", drainCycles);
        checkOutput("overflow drain cycles", 64'(drainCycles), 64'd8);
        checkOutput("drop sticky", {63'd0, drop}, 64'd1);

        $display("[TB] push and pop on a full FIFO");
        doClear(1'b0);
        checkOutput("clear drop", {63'd0, drop}, 64'd0);
        traceReady = 1'b0;
        for (int i = 11; i <= 18; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'(i), 32'h200 + 32'(i), 1'b1);
        end
        checkOutput("exactly full drop", {63'd0, drop}, 64'd0);
        traceReady = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd19, 32'h0000_0213, 1'b1);
        traceReady = 1'b0;
        checkOutput("push+pop drop", {63'd0, drop}, 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd20, 32'h0000_0214, 1'b0);
        checkOutput("still full drop", {63'd0, drop}, 64'd1);
        waitDrain("full", drainCycles);
        checkOutput("full drain cycles", 64'(drainCycles), 64'd8);

        $display("[TB] stall and flush statistics");
        doClear(1'b0);
        traceReady = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_DEAD, 1'b1);
        checkOutput("stall count", 64'(stallCnt), 64'd3);
        checkOutput("flush count", 64'(flushCnt), 64'd2);
        checkOutput("x0 retire", 64'(retireCnt), 64'd0);
        checkOutput("stall cycle", 64'(cycleCnt), 64'd5);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0077, 1'b1);
        checkOutput("stall+wb stall count", 64'(stallCnt), 64'd4);
        checkOutput("stall+wb retire", 64'(retireCnt), 64'd1);
        waitDrain("stall", drainCycles);
        checkOutput("stall drop", {63'd0, drop}, 64'd0);

        $display("[TB] asynchronous reset mid-stream");
        doClear(1'b0);
        traceReady = 1'b0;
        for (int i = 21; i <= 24; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'(i), 32'h300 + 32'(i), 1'b1);
        end
        wbEn = 1'b0;
        checkOutput("queued valid", {63'd0, traceValid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async valid", {63'd0, traceValid}, 64'd0);
        checkOutput("async cycle", 64'(cycleCnt), 64'd0);
        checkOutput("async retire", 64'(retireCnt), 64'd0);
        checkOutput("async drop", {63'd0, drop}, 64'd0);
        checkOutput("async data", traceData, 64'd0);
        expQ.delete();
        expCyc = 32'd0;
        start  = 1'b0;
        tick();
        rst_n      = 1'b1;
        traceReady = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h0000_0099, 1'b1);
        wbEn = 1'b0;
        checkOutput("post-reset valid", {63'd0, traceValid}, 64'd1);
        checkOutput("post-reset stamp", traceData, 64'h0000_0009_0000_0099);
        waitDrain("post-reset", drainCycles);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/pipe_event_tracer.md
Name: pipe_event_tracer

Overview:
- Trace source for the 5-stage pipelined CPU. Sits beside the CPU top and taps the hazard-unit bubble signal, the control flush signal and the MEM/WB writeback signals.
- Keeps the stall/flush/cycle/retire statistics in hardware instead of counting them in the bench.
- Streams one record per register writeback through a buffered valid/ready port, so an external consumer (bench, UART, host) can reconstruct register-file history.

Parameters:
- DEPTH, 8: trace FIFO entries; power of two, minimum 2.
- CNT_W, 32: width of each statistics counter.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  CPU run enable. Counting and tracing occur only while it is 1.
- clear_i  in  1  synchronous clear of counters, FIFO and drop flag.
- stall_i  in  1  hazard-unit bubble, one per stalled cycle.
- flush_i  in  1  control-unit flush, one per flushed cycle.
- wb_en_i  in  1  MEM/WB RegWrite.
- wb_addr_i  in  5  MEM/WB destination register.
- wb_data_i  in  32  writeback data (post mux).
- trace_valid_o  out  1  record available.
- trace_ready_i  in  1  consumer accepts record.
- trace_data_o  out  64  record {cycle[26:0], rd[4:0], data[31:0]}.
- drop_o  out  1  sticky: a record was lost to FIFO full.
- cycle_cnt_o  out  CNT_W  cycles with start_i=1.
- stall_cnt_o  out  CNT_W  cycles with start_i=1 and stall_i=1.
- flush_cnt_o  out  CNT_W  cycles with start_i=1 and flush_i=1.
- retire_cnt_o  out  CNT_W  writeback events (wb_en_i=1, wb_addr_i!=0, start_i=1).

Behaviour:
- Reset (rst_n_i=0, asynchronous, any time including mid-transfer):
  - All counters 0; FIFO empty; trace_valid_o=0; trace_data_o=0; drop_o=0.
- clear_i=1 at a rising edge:
  - Same state as reset. Clear has priority over every event in that cycle; a coincident event is neither counted nor pushed.
- Counters:
  - Update at the rising edge in the cycle their condition holds.
  - Saturate at all-ones; never wrap.
  - stall_i and flush_i in the same cycle increment both counters.
- Event: start_i=1, wb_en_i=1, wb_addr_i!=0. Writes to x0 are not events.
- Record contents: cycle field = cycle_cnt_o[26:0] value before that edge's increment. The first counted cycle stamps 0.
- Push: event at edge N. The record is visible on trace_data_o with trace_valid_o=1 at edge N+1 at the earliest, when the FIFO was empty.
- Output: trace_data_o is the FIFO head, driven from registers. Contents are undefined (hold last value) while trace_valid_o=0.
- Pop: trace_valid_o=1 and trace_ready_i=1 at an edge. The next entry appears the following cycle; back-to-back pops give one record per cycle.
- trace_valid_o rules:
  - Once asserted, it stays 1 and trace_data_o stays stable until the pop.
  - trace_ready_i may toggle freely.
- Full (count==DEPTH):
  - Push without pop: record discarded, drop_o set; it stays set until reset or clear_i.
  - Push with pop in the same edge: both succeed; count unchanged; no drop.
- Empty: a pop is impossible because trace_valid_o=0.
- Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH, plus a separate occupancy count of log2(DEPTH)+1 bits.
- start_i=0: counters hold and no pushes occur. Pops continue, so the FIFO drains.

Optional Feature:
- Macro: TRACE_STALL_EN.
- Defined:
  - A cycle with start_i=1 and (stall_i|flush_i)=1 and no writeback event pushes a marker record {cycle[26:0], 5'd0, 30'd0, flush_i, stall_i}.
  - A writeback event in the same cycle wins; that marker is silently suppressed and does not set drop_o.
  - A marker lost to full sets drop_o.
- Undefined: no marker logic is synthesized; only writeback records are pushed.

Test Plan:
- Reset then start_i=1 for 10 cycles, no events → cycle_cnt_o=10, other counters 0, trace_valid_o=0.
- trace_ready_i=1, one event rd=5, data=0x0000000F in counted cycle 3 → next cycle trace_valid_o=1, trace_data_o=0x000000650000000F (cycle 3, rd 5); retire_cnt_o=1.
- trace_ready_i=0, 10 consecutive events rd=1..10 with DEPTH=8 → 8 records held, drop_o=1, retire_cnt_o=10. Then raise ready → records rd=1..8 in order, one per cycle, then trace_valid_o=0.
- FIFO full, simultaneous event and pop → no drop. Occupancy stays 8; the new record emerges last.
- stall_i=1 for 3 cycles, flush_i=1 for 2 cycles (one overlapping), event with wb_addr_i=0 → stall_cnt_o=3, flush_cnt_o=2, retire_cnt_o=0. With TRACE_STALL_EN: 4 markers; the overlapping one has low bits 2'b11.
- rst_n_i pulsed low mid-stream with 4 queued records and ready=0 → immediately trace_valid_o=0, counters 0, drop_o=0. After release, the first new event stamps cycle 0.
